// File: rtl/uart_echo_core.sv
`timescale 1ns/1ps
// uart_echo_core: UART receiver feeding a small FIFO that drains into a UART
// transmitter gated by clear-to-send. Every received good frame is echoed.
module uart_echo_core #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          uart_rx,
    input  logic                          cts_n,
    output logic                          uart_tx,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          fifo_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV  = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;

    localparam logic [CW-1:0] CNT_BIT   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY == 1);
    localparam logic          HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    // synchronisers
    logic r_rx_meta, r_rx_sync, r_rx_prev;
    logic r_cts_meta, r_cts_sync;

    // receiver
    rx_state_t              r_rx_state;
    logic [CW-1:0]          r_rx_cnt;
    logic [BW-1:0]          r_rx_bit;
    logic                   r_rx_stop;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   r_rx_par_bad;
    logic                   r_rx_push;
    logic                   r_rx_ferr;
    logic                   r_rx_perr;

    // fifo
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic                   r_ovf;

    // transmitter
    tx_state_t              r_tx_state;
    logic [CW-1:0]          r_tx_cnt;
    logic [BW-1:0]          r_tx_bit;
    logic                   r_tx_stop;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic                   r_tx_par;
    logic                   r_tx;

    logic w_rx_fall;
    logic w_full, w_empty;
    logic w_pop, w_wr;

    // A start needs a genuine high-to-low edge; since the delayed copy resets
    // low, the line must be seen high after reset or a break before a start.
    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = (r_tx_state == TX_IDLE) && !w_empty && !r_cts_sync;
    // A full FIFO can still take a byte when the transmitter pops in the same cycle.
    assign w_wr    = r_rx_push && (!w_full || w_pop);

    // two-flop synchronisers plus a delayed rx copy for edge detection
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rx_meta  <= 1'b0;
            r_rx_sync  <= 1'b0;
            r_rx_prev  <= 1'b0;
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_rx_meta  <= uart_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_cts_meta <= cts_n;
            r_cts_sync <= r_cts_meta;
        end
    end

    // receive FSM: mid-bit sampling, parity/stop checks, FIFO write request
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_stop    <= 1'b0;
            r_rx_shift   <= '0;
            r_rx_par_bad <= 1'b0;
            r_rx_push    <= 1'b0;
            r_rx_ferr    <= 1'b0;
            r_rx_perr    <= 1'b0;
        end else begin
            r_rx_push <= 1'b0;
            r_rx_ferr <= 1'b0;
            r_rx_perr <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= CNT_HALF;
                    end
                end
                default: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CW'(1);
                    end else begin
                        r_rx_cnt <= CNT_BIT;
                        case (r_rx_state)
                            RX_START: begin
                                // a high start sample is a glitch: drop silently
                                if (r_rx_sync) begin
                                    r_rx_state <= RX_IDLE;
                                end else begin
                                    r_rx_state   <= RX_DATA;
                                    r_rx_bit     <= '0;
                                    r_rx_stop    <= 1'b0;
                                    r_rx_par_bad <= 1'b0;
                                end
                            end
                            RX_DATA: begin
                                r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                                if (r_rx_bit == LAST_BIT) begin
                                    r_rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                                end else begin
                                    r_rx_bit <= r_rx_bit + BW'(1);
                                end
                            end
                            RX_PARITY: begin
                                r_rx_par_bad <= r_rx_sync ^ (^r_rx_shift) ^ ODD;
                                r_rx_state   <= RX_STOP;
                            end
                            RX_STOP: begin
                                // frame error wins over a pending parity error
                                if (!r_rx_sync) begin
                                    r_rx_ferr  <= 1'b1;
                                    r_rx_state <= RX_IDLE;
                                end else if (r_rx_stop == LAST_STOP) begin
                                    r_rx_state <= RX_IDLE;
                                    if (r_rx_par_bad) r_rx_perr <= 1'b1;
                                    else              r_rx_push <= 1'b1;
                                end else begin
                                    r_rx_stop <= 1'b1;
                                end
                            end
                            default: r_rx_state <= RX_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // FIFO storage; only written when the push is accepted
    always_ff @(posedge sys_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_rx_shift;
    end

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= r_rx_push && !w_wr;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // transmit FSM: pop on IDLE exit, then DIV cycles per bit from a registered output
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_tx_shift <= r_mem[r_rd_ptr];
                        r_tx_par   <= (^r_mem[r_rd_ptr]) ^ ODD;
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= CNT_BIT;
                        r_tx_state <= TX_START;
                    end
                end
                default: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - CW'(1);
                    end else begin
                        r_tx_cnt <= CNT_BIT;
                        case (r_tx_state)
                            TX_START: begin
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                                r_tx_bit   <= '0;
                                r_tx_state <= TX_DATA;
                            end
                            TX_DATA: begin
                                if (r_tx_bit == LAST_BIT) begin
                                    r_tx_stop <= 1'b0;
                                    if (HAS_PAR) begin
                                        r_tx       <= r_tx_par;
                                        r_tx_state <= TX_PARITY;
                                    end else begin
                                        r_tx       <= 1'b1;
                                        r_tx_state <= TX_STOP;
                                    end
                                end else begin
                                    r_tx       <= r_tx_shift[0];
                                    r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                                    r_tx_bit   <= r_tx_bit + BW'(1);
                                end
                            end
                            TX_PARITY: begin
                                r_tx       <= 1'b1;
                                r_tx_stop  <= 1'b0;
                                r_tx_state <= TX_STOP;
                            end
                            TX_STOP: begin
                                if (r_tx_stop == LAST_STOP) begin
                                    r_tx       <= 1'b1;
                                    r_tx_state <= TX_IDLE;
                                end else begin
                                    r_tx_stop <= 1'b1;
                                end
                            end
                            default: begin
                                r_tx       <= 1'b1;
                                r_tx_state <= TX_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign uart_tx       = r_tx;
    assign rx_frame_err  = r_rx_ferr;
    assign rx_parity_err = r_rx_perr;
    assign fifo_overflow = r_ovf;
    assign fifo_level    = r_level;

endmodule

// File: tb/tb_uart_echo_core.sv
`timescale 1ns/1ps
// Bench for uart_echo_core: a default instance (DIV 434) and a fast instance
// (DIV 16, even parity, 4-deep FIFO). A behavioural UART decoder on each
// uart_tx turns the line back into bytes for comparison with expected queues.
module tb_uart_echo_core;

    localparam int DIV_D = (50_000_000 + 115200 / 2) / 115200;
    localparam int DIV_F = (1_000_000 + 62_500 / 2) / 62_500;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx_d = 1'b1, cts_d = 1'b1, tx_d, fe_d, pe_d, ov_d;
    logic [4:0] lvl_d;
    logic       rx_f = 1'b1, cts_f = 1'b1, tx_f, fe_f, pe_f, ov_f;
    logic [2:0] lvl_f;

    int checks = 0;
    int errors = 0;
    int n_fe_d = 0, n_pe_d = 0, n_ov_d = 0;
    int n_fe_f = 0, n_pe_f = 0, n_ov_f = 0;
    int bad_d = 0, bad_f = 0;
    bit mon_en = 1'b0;
    logic [7:0] q_d[$];
    logic [7:0] q_f[$];

    uart_echo_core u_def (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rx(rx_d), .cts_n(cts_d),
        .uart_tx(tx_d), .rx_frame_err(fe_d), .rx_parity_err(pe_d),
        .fifo_overflow(ov_d), .fifo_level(lvl_d)
    );

    uart_echo_core #(
        .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(62_500), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_fp (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rx(rx_f), .cts_n(cts_f),
        .uart_tx(tx_f), .rx_frame_err(fe_f), .rx_parity_err(pe_f),
        .fifo_overflow(ov_f), .fifo_level(lvl_f)
    );

    always #10 sys_clk = ~sys_clk;

    initial begin
        #(20 * 200_000);
        $display("FAIL watchdog: simulation did not complete within 200000 cycles");
        $fatal(1);
    end

    // flag pulse counters
    always @(negedge sys_clk) begin
        if (mon_en) begin
            n_fe_d <= n_fe_d + int'(fe_d);
            n_pe_d <= n_pe_d + int'(pe_d);
            n_ov_d <= n_ov_d + int'(ov_d);
            n_fe_f <= n_fe_f + int'(fe_f);
            n_pe_f <= n_pe_f + int'(pe_f);
            n_ov_f <= n_ov_f + int'(ov_f);
        end
    end

    function automatic logic txv(input bit s);
        return s ? tx_f : tx_d;
    endfunction

    // decode one frame starting at the first low cycle; fast instance carries even parity
    task automatic decode(input bit s, output logic [7:0] d, output bit ok);
        int div = s ? DIV_F : DIV_D;
        ok = 1'b1;
        d  = '0;
        repeat (div / 2) @(negedge sys_clk);
        if (txv(s) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge sys_clk);
            d[i] = txv(s);
        end
        if (s) begin
            repeat (div) @(negedge sys_clk);
            if (txv(s) !== ^d) ok = 1'b0;
        end
        repeat (div) @(negedge sys_clk);
        if (txv(s) !== 1'b1) ok = 1'b0;
    endtask

    always begin : mon_tx_d
        logic [7:0] d;
        bit ok;
        @(negedge sys_clk);
        if (mon_en && tx_d === 1'b0) begin
            decode(1'b0, d, ok);
            q_d.push_back(d);
            if (!ok) bad_d++;
        end
    end

    always begin : mon_tx_f
        logic [7:0] d;
        bit ok;
        @(negedge sys_clk);
        if (mon_en && tx_f === 1'b0) begin
            decode(1'b1, d, ok);
            q_f.push_back(d);
            if (!ok) bad_f++;
        end
    end

    task automatic drive_rx(input bit s, input logic b);
        if (s) rx_f = b;
        else   rx_d = b;
    endtask

    // serialise one frame onto the chosen rx line; bad_par flips the parity bit
    task automatic send_byte(input bit s, input logic [7:0] d, input bit bad_par);
        int div = s ? DIV_F : DIV_D;
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (s) bits.push_back((^d) ^ bad_par);
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            drive_rx(s, bits[k]);
            repeat (div) @(negedge sys_clk);
        end
    endtask

    task automatic test_reset();
        rx_d = 1'b0; rx_f = 1'b1; cts_d = 1'b0; cts_f = 1'b1;
        sys_rst_n = 1'b0;
        repeat (5) @(negedge sys_clk);
        checks++;
        if (tx_d !== 1'b1 || lvl_d !== 5'd0 || fe_d !== 1'b0 || pe_d !== 1'b0 || ov_d !== 1'b0)
            begin errors++; $display("FAIL reset_def: tx=%b lvl=%0d fe=%b pe=%b ov=%b, want 1 0 0 0 0", tx_d, lvl_d, fe_d, pe_d, ov_d); end
        checks++;
        if (tx_f !== 1'b1 || lvl_f !== 3'd0 || fe_f !== 1'b0 || pe_f !== 1'b0 || ov_f !== 1'b0)
            begin errors++; $display("FAIL reset_fp: tx=%b lvl=%0d fe=%b pe=%b ov=%b, want 1 0 0 0 0", tx_f, lvl_f, fe_f, pe_f, ov_f); end
        sys_rst_n = 1'b1;
        mon_en = 1'b1;
        // line held low after reset: no start may be taken
        repeat (11 * DIV_D) @(negedge sys_clk);
        checks++;
        if (n_fe_d !== 0 || lvl_d !== 5'd0 || tx_d !== 1'b1 || q_d.size() != 0)
            begin errors++; $display("FAIL reset_rx_low: fe=%0d lvl=%0d tx=%b out=%0d, want 0 0 1 0", n_fe_d, lvl_d, tx_d, q_d.size()); end
        rx_d = 1'b1;
        repeat (DIV_D) @(negedge sys_clk);
    endtask

    task automatic test_loopback();
        logic [7:0] d = 8'h41;
        fork
            send_byte(1'b0, d, 1'b0);
            begin
                int t = 0;
                while (lvl_d !== 5'd1 && t < 12 * DIV_D) begin
                    @(negedge sys_clk);
                    t++;
                end
                checks++;
                if (lvl_d !== 5'd1) begin
                    errors++; $display("FAIL loop_push: fifo_level=%0d, want 1 before timeout", lvl_d);
                end else begin
                    checks++;
                    if (tx_d !== 1'b1) begin errors++; $display("FAIL loop_pop_cycle: tx=%b, want 1", tx_d); end
                    @(negedge sys_clk);
                    checks++;
                    if (lvl_d !== 5'd0 || tx_d !== 1'b0)
                        begin errors++; $display("FAIL loop_start_pop1: lvl=%0d tx=%b, want 0 0", lvl_d, tx_d); end
                    for (int k = 0; k < 10; k++) begin
                        logic exp;
                        int bad = 0;
                        exp = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : 1'b1;
                        for (int c = 0; c < DIV_D; c++) begin
                            if (tx_d !== exp) bad++;
                            @(negedge sys_clk);
                        end
                        checks++;
                        if (bad != 0) begin errors++; $display("FAIL loop_bit%0d: %0d of %0d cycles differ, want level %b", k, bad, DIV_D, exp); end
                    end
                    checks++;
                    if (tx_d !== 1'b1) begin errors++; $display("FAIL loop_idle: tx=%b, want 1", tx_d); end
                end
            end
        join
        checks++;
        if (q_d.size() != 1 || q_d[0] !== d || bad_d != 0)
            begin errors++; $display("FAIL loop_decode: n=%0d byte=%h bad=%0d, want 1 41 0", q_d.size(), (q_d.size() > 0) ? q_d[0] : 8'h00, bad_d); end
        q_d.delete();
    endtask

    task automatic test_glitch();
        int fe0 = n_fe_d;
        int pe0 = n_pe_d;
        rx_d = 1'b0;
        repeat (100) @(negedge sys_clk);
        rx_d = 1'b1;
        repeat (11 * DIV_D) @(negedge sys_clk);
        checks++;
        if (n_fe_d != fe0 || n_pe_d != pe0 || lvl_d !== 5'd0 || q_d.size() != 0)
            begin errors++; $display("FAIL glitch: fe+%0d pe+%0d lvl=%0d out=%0d, want all 0", n_fe_d - fe0, n_pe_d - pe0, lvl_d, q_d.size()); end
    endtask

    task automatic test_break();
        int fe0 = n_fe_d;
        int t = 0;
        rx_d = 1'b0;
        repeat (30 * DIV_D) @(negedge sys_clk);
        rx_d = 1'b1;
        repeat (2 * DIV_D) @(negedge sys_clk);
        checks++;
        if (n_fe_d - fe0 != 1 || lvl_d !== 5'd0 || q_d.size() != 0)
            begin errors++; $display("FAIL break: frame_err pulses=%0d lvl=%0d out=%0d, want 1 0 0", n_fe_d - fe0, lvl_d, q_d.size()); end
        send_byte(1'b0, 8'h5A, 1'b0);
        while (q_d.size() < 1 && t < 12 * DIV_D) begin @(negedge sys_clk); t++; end
        checks++;
        if (q_d.size() != 1 || q_d[0] !== 8'h5A)
            begin errors++; $display("FAIL break_recover: n=%0d byte=%h, want 1 5a", q_d.size(), (q_d.size() > 0) ? q_d[0] : 8'h00); end
        q_d.delete();
    endtask

    task automatic test_stream();
        string s = "Hello, world!";
        int mx = 0;
        int fe0 = n_fe_f, pe0 = n_pe_f, ov0 = n_ov_f;
        cts_f = 1'b0;
        repeat (4) @(negedge sys_clk);
        fork
            for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i], 1'b0);
            for (int c = 0; c < 15 * 11 * DIV_F; c++) begin
                if (int'(lvl_f) > mx) mx = int'(lvl_f);
                @(negedge sys_clk);
            end
        join
        checks++;
        if (q_f.size() != s.len()) begin errors++; $display("FAIL stream_count: got %0d bytes, want %0d", q_f.size(), s.len()); end
        for (int i = 0; i < s.len() && i < q_f.size(); i++) begin
            checks++;
            if (q_f[i] !== s[i]) begin errors++; $display("FAIL stream_byte%0d: got %h want %h", i, q_f[i], s[i]); end
        end
        checks++;
        if (mx > 1 || n_fe_f != fe0 || n_pe_f != pe0 || n_ov_f != ov0 || bad_f != 0)
            begin errors++; $display("FAIL stream_flags: maxlvl=%0d fe+%0d pe+%0d ov+%0d badframes=%0d, want <=1 0 0 0 0", mx, n_fe_f - fe0, n_pe_f - pe0, n_ov_f - ov0, bad_f); end
        q_f.delete();
    endtask

    task automatic test_parity();
        int pe0 = n_pe_f, fe0 = n_fe_f;
        int bad = 0;
        fork
            send_byte(1'b1, 8'h41, 1'b1);
            for (int c = 0; c < 13 * DIV_F; c++) begin
                if (tx_f !== 1'b1 || lvl_f !== 3'd0) bad++;
                @(negedge sys_clk);
            end
        join
        checks++;
        if (n_pe_f - pe0 != 1 || n_fe_f != fe0)
            begin errors++; $display("FAIL parity_pulse: parity_err=%0d frame_err=%0d, want 1 0", n_pe_f - pe0, n_fe_f - fe0); end
        checks++;
        if (bad != 0 || q_f.size() != 0)
            begin errors++; $display("FAIL parity_discard: busy cycles=%0d out=%0d, want 0 0", bad, q_f.size()); end
    endtask

    task automatic test_overflow();
        int ov0 = n_ov_f;
        int t = 0;
        cts_f = 1'b1;
        repeat (4) @(negedge sys_clk);
        for (int i = 1; i <= 4; i++) send_byte(1'b1, 8'(i), 1'b0);
        checks++;
        if (lvl_f !== 3'd4 || n_ov_f != ov0)
            begin errors++; $display("FAIL ovf_fill: lvl=%0d ovf=%0d, want 4 0", lvl_f, n_ov_f - ov0); end
        send_byte(1'b1, 8'h05, 1'b0);
        checks++;
        if (lvl_f !== 3'd4 || n_ov_f - ov0 != 1 || q_f.size() != 0)
            begin errors++; $display("FAIL ovf_drop: lvl=%0d ovf=%0d out=%0d, want 4 1 0", lvl_f, n_ov_f - ov0, q_f.size()); end
        cts_f = 1'b0;
        while (q_f.size() < 4 && t < 6 * 11 * DIV_F) begin @(negedge sys_clk); t++; end
        repeat (2 * 11 * DIV_F) @(negedge sys_clk);
        checks++;
        if (q_f.size() != 4 || lvl_f !== 3'd0)
            begin errors++; $display("FAIL ovf_drain: out=%0d lvl=%0d, want 4 0", q_f.size(), lvl_f); end
        for (int i = 0; i < 4 && i < q_f.size(); i++) begin
            checks++;
            if (q_f[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", i, q_f[i], 8'(i + 1)); end
        end
        q_f.delete();
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        int pe0 = n_pe_f;
        int nbad = 0;
        cts_f = 1'b0;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d = 8'($urandom);
            bit bp = ($urandom_range(0, 4) == 0);
            send_byte(1'b1, d, bp);
            if (bp) nbad++;
            else    exp.push_back(d);
            repeat ($urandom_range(0, 3 * DIV_F)) @(negedge sys_clk);
        end
        repeat (3 * 11 * DIV_F) @(negedge sys_clk);
        checks++;
        if (q_f.size() != exp.size() || n_pe_f - pe0 != nbad)
            begin errors++; $display("FAIL random_count: out=%0d parity_err=%0d, want %0d %0d", q_f.size(), n_pe_f - pe0, exp.size(), nbad); end
        for (int i = 0; i < exp.size() && i < q_f.size(); i++) begin
            checks++;
            if (q_f[i] !== exp[i]) begin errors++; $display("FAIL random_byte%0d: got %h want %h", i, q_f[i], exp[i]); end
        end
        q_f.delete();
    endtask

    task automatic test_midframe_reset();
        int fe0 = n_fe_f, pe0 = n_pe_f, ov0 = n_ov_f;
        int t = 0;
        logic b[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        cts_f = 1'b1;
        repeat (4) @(negedge sys_clk);
        foreach (b[k]) begin
            rx_f = b[k];
            repeat (DIV_F) @(negedge sys_clk);
        end
        sys_rst_n = 1'b0;
        rx_f = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (tx_f !== 1'b1 || lvl_f !== 3'd0)
            begin errors++; $display("FAIL midreset_state: tx=%b lvl=%0d, want 1 0", tx_f, lvl_f); end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (12 * DIV_F) @(negedge sys_clk);
        checks++;
        if (n_fe_f != fe0 || n_pe_f != pe0 || n_ov_f != ov0 || lvl_f !== 3'd0)
            begin errors++; $display("FAIL midreset_flags: fe+%0d pe+%0d ov+%0d lvl=%0d, want 0 0 0 0", n_fe_f - fe0, n_pe_f - pe0, n_ov_f - ov0, lvl_f); end
        cts_f = 1'b0;
        send_byte(1'b1, 8'hC3, 1'b0);
        while (q_f.size() < 1 && t < 14 * DIV_F) begin @(negedge sys_clk); t++; end
        checks++;
        if (q_f.size() != 1 || q_f[0] !== 8'hC3)
            begin errors++; $display("FAIL midreset_recover: n=%0d byte=%h, want 1 c3", q_f.size(), (q_f.size() > 0) ? q_f[0] : 8'h00); end
        q_f.delete();
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_glitch();
        test_break();
        test_stream();
        test_parity();
        test_overflow();
        test_random();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
